// File: rtl/hazard_control.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes,
// multi-cycle multiply occupancy of EX, and a saturating stall-cycle counter.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ID_RS, ID_RT            source registers of the instruction in ID
//   ID_USES_RT              ID instruction reads RT
//   ID_MUL                  ID instruction is a multiply
//   EX_RD, EX_MEMREAD       destination / load flag of the instruction in EX
//   BR_TAKEN                branch in EX resolved taken
//   CNT_CLR                 synchronous clear of STALL_CNT
//   PC_WRITE, IFID_WRITE    fetch-side load enables
//   IFID_FLUSH              squash IF/ID into a NOP
//   IDEX_BUBBLE             load NOP control into ID/EX
//   MUL_START, MUL_BUSY     multiply issue pulse / EX occupied by multiply
//   STALL_CNT               saturating count of cycles with PC_WRITE=0
module hazard_control #(
    parameter int REG_W   = 4,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ID_RS,
    input  logic [REG_W-1:0] ID_RT,
    input  logic             ID_USES_RT,
    input  logic             ID_MUL,
    input  logic [REG_W-1:0] EX_RD,
    input  logic             EX_MEMREAD,
    input  logic             BR_TAKEN,
    input  logic             CNT_CLR,
    output logic             PC_WRITE,
    output logic             IFID_WRITE,
    output logic             IFID_FLUSH,
    output logic             IDEX_BUBBLE,
    output logic             MUL_START,
    output logic             MUL_BUSY,
    output logic [CNT_W-1:0] STALL_CNT
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MULWAIT = 2'b10
    } state_t;

    // Issue cycle counts as one stall cycle, so MULWAIT lasts MUL_LAT-1
    // cycles: MCNT runs from MUL_LAT-2 down to 0.
    localparam logic [3:0]       MCNT_INIT = 4'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t     state;
    state_t     state_nxt;
    logic [3:0] mcnt;
    logic [3:0] mcnt_nxt;
    logic       hazard;

    // Register 0 is hard-wired, so a load targeting it never blocks ID.
    always_comb begin
        hazard = EX_MEMREAD && (EX_RD != '0) &&
                 ((EX_RD == ID_RS) ||
                  (ID_USES_RT && (EX_RD == ID_RT)));
    end

    always_comb begin
        PC_WRITE    = 1'b1;
        IFID_WRITE  = 1'b1;
        IFID_FLUSH  = 1'b0;
        IDEX_BUBBLE = 1'b0;
        MUL_START   = 1'b0;
        MUL_BUSY    = 1'b0;
        state_nxt   = RUN;
        mcnt_nxt    = mcnt;

        if (state == MULWAIT) begin
            // EX holds the multiply; branch, hazard and new multiplies wait.
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_BUBBLE = 1'b1;
            MUL_BUSY    = 1'b1;
            if (mcnt != 4'd0) begin
                mcnt_nxt  = mcnt - 4'd1;
                state_nxt = MULWAIT;
            end else begin
                state_nxt = RUN;
            end
        end else begin
            // Unused encodings fall through here and behave as RUN.
            if (BR_TAKEN) begin
                // ID instruction is squashed, so its hazard/multiply is moot.
                IFID_FLUSH  = 1'b1;
                IDEX_BUBBLE = 1'b1;
            end else if (hazard) begin
                PC_WRITE    = 1'b0;
                IFID_WRITE  = 1'b0;
                IDEX_BUBBLE = 1'b1;
            end else if (ID_MUL) begin
                // The multiply itself advances into EX, so no bubble.
                PC_WRITE   = 1'b0;
                IFID_WRITE = 1'b0;
                MUL_START  = 1'b1;
                state_nxt  = MULWAIT;
                mcnt_nxt   = MCNT_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            mcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            mcnt  <= mcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            STALL_CNT <= '0;
        end else if (CNT_CLR) begin
            STALL_CNT <= '0;
        end else if (!PC_WRITE && (STALL_CNT != CNT_MAX)) begin
            STALL_CNT <= STALL_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: expected control vectors are queued
// as each step is driven and compared when the outputs settle.
module tb_hazard_control;

    logic       clk;
    logic       rst_n;
    logic [3:0] ID_RS;
    logic [3:0] ID_RT;
    logic       ID_USES_RT;
    logic       ID_MUL;
    logic [3:0] EX_RD;
    logic       EX_MEMREAD;
    logic       BR_TAKEN;
    logic       CNT_CLR;
    logic       PC_WRITE;
    logic       IFID_WRITE;
    logic       IFID_FLUSH;
    logic       IDEX_BUBBLE;
    logic       MUL_START;
    logic       MUL_BUSY;
    logic [7:0] STALL_CNT;

    hazard_control #(.REG_W(4), .MUL_LAT(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ID_RS(ID_RS),
        .ID_RT(ID_RT),
        .ID_USES_RT(ID_USES_RT),
        .ID_MUL(ID_MUL),
        .EX_RD(EX_RD),
        .EX_MEMREAD(EX_MEMREAD),
        .BR_TAKEN(BR_TAKEN),
        .CNT_CLR(CNT_CLR),
        .PC_WRITE(PC_WRITE),
        .IFID_WRITE(IFID_WRITE),
        .IFID_FLUSH(IFID_FLUSH),
        .IDEX_BUBBLE(IDEX_BUBBLE),
        .MUL_START(MUL_START),
        .MUL_BUSY(MUL_BUSY),
        .STALL_CNT(STALL_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_BUBBLE, MUL_START, MUL_BUSY}
    localparam logic [5:0] C_RUN   = 6'b110000;
    localparam logic [5:0] C_STALL = 6'b000100;
    localparam logic [5:0] C_FLUSH = 6'b111100;
    localparam logic [5:0] C_MSTRT = 6'b000010;
    localparam logic [5:0] C_MBUSY = 6'b000101;

    typedef struct {
        string      tag;
        logic [5:0] ctl;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    function automatic logic [5:0] obs_ctl();
        return {PC_WRITE, IFID_WRITE, IFID_FLUSH,
                IDEX_BUBBLE, MUL_START, MUL_BUSY};
    endfunction

    task automatic expect_now(input string tag, input logic [5:0] ctl);
        sb.push_back('{tag, ctl, exp_cnt});
    endtask

    task automatic check_now();
        exp_t e;
        logic [5:0] o;
        e = sb.pop_front();
        o = obs_ctl();
        checks++;
        assert (o === e.ctl) else begin
            errors++;
            $error("FAIL %s ctl observed=%b expected=%b", e.tag, o, e.ctl);
        end
        checks++;
        assert (STALL_CNT === e.cnt) else begin
            errors++;
            $error("FAIL %s cnt observed=%0d expected=%0d",
                   e.tag, STALL_CNT, e.cnt);
        end
    endtask

    // Inputs are already driven (just after a rising edge); check mid-cycle,
    // then advance the counter model across the next edge.
    task automatic cyc(input string tag, input logic [5:0] ctl);
        expect_now(tag, ctl);
        @(negedge clk);
        check_now();
        if (CNT_CLR) exp_cnt = 8'd0;
        else if (!ctl[5] && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ID_RS = 4'h0; ID_RT = 4'h0; ID_USES_RT = 1'b0; ID_MUL = 1'b0;
        EX_RD = 4'h0; EX_MEMREAD = 1'b0; BR_TAKEN = 1'b0; CNT_CLR = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        expect_now("reset", C_RUN);
        check_now();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc("idle", C_RUN);

        // load-use on RS
        EX_MEMREAD = 1'b1; EX_RD = 4'h8; ID_RS = 4'h8;
        cyc("lu_rs", C_STALL);
        EX_MEMREAD = 1'b0;
        cyc("lu_rs_after", C_RUN);

        // load-use on RT, with and without RT use
        EX_MEMREAD = 1'b1; EX_RD = 4'hF; ID_RS = 4'h0;
        ID_RT = 4'hF; ID_USES_RT = 1'b1;
        cyc("lu_rt", C_STALL);
        ID_USES_RT = 1'b0;
        cyc("lu_rt_unused", C_RUN);

        // register 0 never stalls
        EX_RD = 4'h0; ID_RS = 4'h0;
        cyc("lu_r0", C_RUN);
        idle_inputs();

        CNT_CLR = 1'b1;
        cyc("clr_idle", C_RUN);
        CNT_CLR = 1'b0;

        // single multiply, MUL_LAT=4
        ID_MUL = 1'b1;
        cyc("mul_start", C_MSTRT);
        ID_MUL = 1'b0;
        cyc("mul_busy1", C_MBUSY);
        cyc("mul_busy2", C_MBUSY);
        cyc("mul_busy3", C_MBUSY);
        cyc("mul_done", C_RUN);
        if (exp_cnt != 8'd4) $display("note: model count %0d", exp_cnt);

        // branch beats hazard and multiply
        BR_TAKEN = 1'b1; EX_MEMREAD = 1'b1; EX_RD = 4'h8;
        ID_RS = 4'h8; ID_MUL = 1'b1;
        cyc("br_prio", C_FLUSH);
        idle_inputs();
        cyc("br_after", C_RUN);

        // branch ignored inside MULWAIT, then back-to-back multiply
        ID_MUL = 1'b1;
        cyc("mul2_start", C_MSTRT);
        BR_TAKEN = 1'b1;
        cyc("mul2_busy1", C_MBUSY);
        cyc("mul2_busy2", C_MBUSY);
        cyc("mul2_busy3", C_MBUSY);
        BR_TAKEN = 1'b0;
        cyc("mul3_start", C_MSTRT);
        ID_MUL = 1'b0;
        cyc("mul3_busy1", C_MBUSY);
        cyc("mul3_busy2", C_MBUSY);
        cyc("mul3_busy3", C_MBUSY);
        cyc("mul3_done", C_RUN);

        // hazard delays a pending multiply by one bubble
        EX_MEMREAD = 1'b1; EX_RD = 4'h8; ID_RS = 4'h8; ID_MUL = 1'b1;
        cyc("hz_mul", C_STALL);
        EX_MEMREAD = 1'b0;
        cyc("hz_mul_start", C_MSTRT);
        ID_MUL = 1'b0;
        cyc("hz_mul_busy1", C_MBUSY);
        cyc("hz_mul_busy2", C_MBUSY);
        cyc("hz_mul_busy3", C_MBUSY);
        cyc("hz_mul_done", C_RUN);
        idle_inputs();

        // asynchronous reset during the second MULWAIT cycle
        ID_MUL = 1'b1;
        cyc("rst_mul_start", C_MSTRT);
        ID_MUL = 1'b0;
        cyc("rst_mul_busy1", C_MBUSY);
        #1;
        expect_now("rst_mul_busy2", C_MBUSY);
        check_now();
        rst_n = 1'b0;
        exp_cnt = 8'd0;
        #1;
        expect_now("rst_async", C_RUN);
        check_now();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst_release", C_RUN);

        // saturation under a long load-use stall
        EX_MEMREAD = 1'b1; EX_RD = 4'h8; ID_RS = 4'h8;
        for (int i = 0; i < 300; i++) cyc("sat", C_STALL);
        CNT_CLR = 1'b1;
        cyc("sat_clr", C_STALL);
        CNT_CLR = 1'b0;
        cyc("sat_cleared", C_STALL);
        idle_inputs();
        cyc("sat_end", C_RUN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
